// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared pipeline constants for the data-memory SRAM path
package sram_controller_pkg;

  localparam int DMEM_BASE_ADDR = 1024;
  localparam int SRAM_ADDR_W    = 18;
  localparam int SRAM_DATA_W    = 16;

  // Decode opcodes that produce mem_read / mem_write; kept here so LD/ST stay in step.
  localparam logic [5:0] OP_LD = 6'h23;
  localparam logic [5:0] OP_ST = 6'h2b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_e;

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - splits a 32-bit load/store into two timed 16-bit async SRAM accesses
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int SRAM_AW     = SRAM_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  sram_state_e        state, state_nxt;
  logic [CW-1:0]      counter, counter_nxt;
  logic               op_wr;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        wdata;
  logic [15:0]        rdata_lo;

  logic               req;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word_in;
  logic               unused_addr_bits;
  logic               lo_capture, hi_capture;

  logic               cur_wr;
  logic [SRAM_AW-2:0] cur_word;
  logic [31:0]        cur_wdata;
  logic [SRAM_AW-1:0] addr_nxt;
  logic [15:0]        dq_nxt;
  logic               oe_nxt, we_n_nxt;

  assign req              = mem_read | mem_write;
  assign offset           = address - 32'(BASE_ADDR);
  assign word_in          = offset[SRAM_AW:2];
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign ready            = ~req | (state == DONE);

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    lo_capture  = 1'b0;
    hi_capture  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt   = LOW;
          counter_nxt = CNT_LOAD;
        end
      end
      LOW: begin
        if (counter == '0) begin
          state_nxt   = HIGH;
          counter_nxt = CNT_LOAD;
          lo_capture  = ~op_wr;
        end else begin
          counter_nxt = counter - CW'(1);
        end
      end
      HIGH: begin
        if (counter == '0) begin
          state_nxt  = DONE;
          hi_capture = ~op_wr;
        end else begin
          counter_nxt = counter - CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus pins are registered from the next state so we_n/oe never glitch toward the SRAM.
  always_comb begin
    cur_wr    = (state == IDLE) ? mem_write  : op_wr;
    cur_word  = (state == IDLE) ? word_in    : word;
    cur_wdata = (state == IDLE) ? write_data : wdata;
    addr_nxt  = sram_addr;
    dq_nxt    = sram_dq_out;
    oe_nxt    = 1'b0;
    we_n_nxt  = 1'b1;
    if (state_nxt == LOW || state_nxt == HIGH) begin
      addr_nxt = {cur_word, state_nxt == HIGH};
      oe_nxt   = cur_wr;
      we_n_nxt = ~cur_wr;
      if (cur_wr) begin
        dq_nxt = (state_nxt == HIGH) ? cur_wdata[31:16] : cur_wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      op_wr       <= 1'b0;
      word        <= '0;
      wdata       <= '0;
      rdata_lo    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state       <= state_nxt;
      counter     <= counter_nxt;
      sram_addr   <= addr_nxt;
      sram_dq_out <= dq_nxt;
      sram_dq_oe  <= oe_nxt;
      sram_we_n   <= we_n_nxt;
      if (state == IDLE && req) begin
        op_wr <= mem_write;
        word  <= word_in;
        wdata <= write_data;
      end
      if (lo_capture) rdata_lo <= sram_dq_in;
      if (hi_capture) read_data <= {sram_dq_in, rdata_lo};
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller against a behavioural async SRAM
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          start;
    bit          wr;
    logic [31:0] a_lo;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  logic [15:0] mem [0:262143];

  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(1024), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   k;
    logic h;
    if (!rst && q.size() != 0) begin
      e = q[0];
      k = cyc - e.start;
      if (k == 0) begin
        chk("ready_c0", 32'(ready), 32'd0);
      end else if (k <= 4) begin
        h = (k >= 3);
        chk("ready_busy", 32'(ready), 32'd0);
        chk("sram_addr", 32'(sram_addr), e.a_lo | 32'(h));
        chk("we_n", 32'(sram_we_n), 32'(!e.wr));
        chk("oe", 32'(sram_dq_oe), 32'(e.wr));
        if (e.wr) chk("dq_out", 32'(sram_dq_out), h ? {16'd0, e.data[31:16]} : {16'd0, e.data[15:0]});
      end else begin
        chk("ready_done", 32'(ready), 32'd1);
        chk("we_n_done", 32'(sram_we_n), 32'd1);
        chk("oe_done", 32'(sram_dq_oe), 32'd0);
        if (!e.wr) chk("read_data", read_data, e.data);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_empty();
    int i = 0;
    while (q.size() != 0 && i < 30) begin
      @(negedge clk); #1;
      i++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d transactions outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic push_exp(input bit wr, input logic [31:0] a_lo, input logic [31:0] data);
    exp_t e;
    e.start = cyc;
    e.wr    = wr;
    e.a_lo  = a_lo;
    e.data  = data;
    q.push_back(e);
  endtask

  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] a_lo,
                        input logic [31:0] exp_data, input bit hold);
    @(posedge clk); #1;
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wd;
    push_exp(wr, a_lo, exp_data);
    wait_empty();
    if (!hold) begin
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);

    do_txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1'b0);
    do_txn(1'b1, 1'b0, 32'd1024, 32'h0, 32'd0, 32'hDEADBEEF, 1'b0);
    repeat (10) @(negedge clk);
    chk("read_data_hold", read_data, 32'hDEADBEEF);

    do_txn(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 32'd2, 32'hCAFEF00D, 1'b0);
    do_txn(1'b1, 1'b0, 32'd1031, 32'h0, 32'd2, 32'hCAFEF00D, 1'b0);

    do_txn(1'b1, 1'b1, 32'd1036, 32'h0BADC0DE, 32'd6, 32'h0BADC0DE, 1'b1);
    do_txn(1'b1, 1'b1, 32'd1036, 32'h0BADC0DE, 32'd6, 32'h0BADC0DE, 1'b0);
    @(negedge clk);
    chk("write_keeps_rdata", read_data, 32'hCAFEF00D);
    do_txn(1'b1, 1'b0, 32'd1036, 32'h0, 32'd6, 32'h0BADC0DE, 1'b0);

    @(posedge clk); #1;
    mem_write  = 1'b1;
    address    = 32'd1032;
    write_data = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_c3_we_n", 32'(sram_we_n), 32'd0);
    chk("abort_c3_addr", 32'(sram_addr), 32'd5);
    chk("abort_c3_dq", 32'(sram_dq_out), 32'h1234);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(1'b1, 32'd4, 32'h12345678);
    @(negedge clk);
    chk("abort_idle_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_idle_oe", 32'(sram_dq_oe), 32'd0);
    wait_empty();
    @(posedge clk); #1;
    mem_write = 1'b0;

    do_txn(1'b1, 1'b0, 32'd1032, 32'h0, 32'd4, 32'h12345678, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
